// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter (dm_arbiter).
// Optional statistics counters are enabled with the DM_ARB_STATS_EN macro.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } owner_t;

  localparam int unsigned DEF_MAX_WAIT = 15;

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Saturating 16-bit increment.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// Debug starvation counter: counts cycles the debug port waits while the
// CPU owns the memory, and flags when debug must be given priority.
module dm_arb_starve_cnt
  import dm_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       dbg_req,
  input  logic       dbg_grant,
  input  logic       dbg_active,
  output logic [7:0] wait_cnt,
  output logic       escalate
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  // Count waiting cycles, clear on a debug grant, hold when debug is quiet.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= 8'd0;
    end else if (dbg_grant) begin
      wait_cnt <= 8'd0;
    end else if (dbg_req && !dbg_active) begin
      wait_cnt <= sat_inc8(wait_cnt);
    end else begin
      wait_cnt <= wait_cnt;
    end
  end

  // Escalation once debug has waited long enough.
  always_comb begin
    escalate = 1'b0;
    if (wait_cnt >= MAX_WAIT_C) begin
      escalate = 1'b1;
    end else begin
      escalate = 1'b0;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Arbiter sharing one single-port data memory between the CPU data port
// and the PDU debug port. CPU has fixed priority; debug escalates after
// MAX_WAIT waiting cycles. Each access runs IDLE -> ACC -> RESP.
// Define DM_ARB_STATS_EN to add grant and peak-wait statistics ports.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_spo,
  output logic              busy
`ifdef DM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu,
  output logic [15:0]       stat_dbg,
  output logic [7:0]        stat_maxwait
`endif
);

  state_t              state_r;
  owner_t              owner_r;
  logic                any_req_s;
  logic                dbg_wins_s;
  logic                dbg_grant_s;
  logic                dbg_active_s;
  logic                sel_we_s;
  logic [ADDR_W-1:0]   sel_addr_s;
  logic [DATA_W-1:0]   sel_wdata_s;
  logic [7:0]          wait_cnt_s;
  logic                escalate_s;
  logic                unused_s;

  // Byte-offset and high address bits are deliberately ignored.
  assign unused_s = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                      dbg_addr[31:ADDR_W+2], dbg_addr[1:0], wait_cnt_s};

  dm_arb_starve_cnt #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk        (clk),
    .rstn       (rstn),
    .dbg_req    (dbg_req),
    .dbg_grant  (dbg_grant_s),
    .dbg_active (dbg_active_s),
    .wait_cnt   (wait_cnt_s),
    .escalate   (escalate_s)
  );

  // Winner selection and request mux used when leaving IDLE.
  always_comb begin
    any_req_s    = cpu_req | dbg_req;
    dbg_wins_s   = 1'b0;
    dbg_grant_s  = 1'b0;
    dbg_active_s = 1'b0;
    if (dbg_req && (escalate_s || !cpu_req)) begin
      dbg_wins_s = 1'b1;
    end else begin
      dbg_wins_s = 1'b0;
    end
    if ((state_r == IDLE) && dbg_wins_s) begin
      dbg_grant_s = 1'b1;
    end else begin
      dbg_grant_s = 1'b0;
    end
    if ((state_r != IDLE) && (owner_r == OWN_DBG)) begin
      dbg_active_s = 1'b1;
    end else begin
      dbg_active_s = 1'b0;
    end
    if (dbg_wins_s) begin
      sel_we_s    = dbg_we;
      sel_addr_s  = dbg_addr[ADDR_W+1:2];
      sel_wdata_s = dbg_wdata;
    end else begin
      sel_we_s    = cpu_we;
      sel_addr_s  = cpu_addr[ADDR_W+1:2];
      sel_wdata_s = cpu_wdata;
    end
  end

  // Access FSM with registered memory controls, acks and read data.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      owner_r   <= OWN_CPU;
      mem_a     <= '0;
      mem_d     <= '0;
      mem_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          if (any_req_s) begin
            state_r <= ACC;
            owner_r <= dbg_wins_s ? OWN_DBG : OWN_CPU;
            mem_we  <= sel_we_s;
            mem_a   <= sel_addr_s;
            mem_d   <= sel_wdata_s;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
            mem_we  <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ACC: begin
          state_r <= RESP;
          mem_we  <= 1'b0;
          busy    <= 1'b1;
          if (owner_r == OWN_DBG) begin
            dbg_rdata <= mem_spo;
            dbg_ack   <= 1'b1;
          end else begin
            cpu_rdata <= mem_spo;
            cpu_ack   <= 1'b1;
          end
        end
        RESP: begin
          state_r <= IDLE;
          mem_we  <= 1'b0;
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          mem_we  <= 1'b0;
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DM_ARB_STATS_EN
  // Grant counters per owner and peak observed debug wait.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_cpu     <= 16'd0;
      stat_dbg     <= 16'd0;
      stat_maxwait <= 8'd0;
    end else begin
      if ((state_r == IDLE) && any_req_s) begin
        if (dbg_wins_s) begin
          stat_dbg <= sat_inc16(stat_dbg);
        end else begin
          stat_cpu <= sat_inc16(stat_cpu);
        end
      end else begin
        stat_cpu <= stat_cpu;
        stat_dbg <= stat_dbg;
      end
      if (wait_cnt_s > stat_maxwait) begin
        stat_maxwait <= wait_cnt_s;
      end else begin
        stat_maxwait <= stat_maxwait;
      end
    end
  end
`endif

endmodule
